// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : In-order instruction queue between fetch and decode. Holds up
//                to DEPTH entries of {pc, instr, miss, illegal, invalid} and
//                presents the oldest one to decode. Flush empties it at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push_valid,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        push_miss,
  input  logic        push_illegal,
  input  logic        push_invalid,
  output logic        push_ready,
  input  logic        pop_ready,
  output logic        pop_valid,
  output logic [31:0] pop_pc,
  output logic [31:0] pop_instr,
  output logic        pop_miss,
  output logic        pop_illegal,
  output logic        pop_invalid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 67;
  localparam logic [AW:0]   C_FULL    = DEPTH[AW:0];
  localparam logic [AW:0]   C_CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] C_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_push_fire;
  logic          w_pop_fire;
  logic [EW-1:0] w_head;

  // Ready/valid come only from the registered occupancy, so a pop in the
  // same cycle cannot open a slot for a push while full.
  assign push_ready  = (r_count != C_FULL);
  assign pop_valid   = (r_count != '0);
  assign w_push_fire = push_valid & push_ready;
  assign w_pop_fire  = pop_valid & pop_ready;
  assign count       = r_count;

  // Storage write; contents are deliberately left untouched by reset/flush.
  always_ff @(posedge clk) begin
    if (w_push_fire && !flush) begin
      r_mem[r_wr_ptr] <= {push_pc, push_instr, push_miss, push_illegal, push_invalid};
    end
  end

  // Pointer and occupancy update; flush overrides any push/pop this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop_fire) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push_fire, w_pop_fire})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head read, forced to an all-zero NOP when the queue is empty.
  always_comb begin
    w_head = '0;
    if (pop_valid) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign pop_pc      = w_head[66:35];
  assign pop_instr   = w_head[34:3];
  assign pop_miss    = w_head[2];
  assign pop_illegal = w_head[1];
  assign pop_invalid = w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_queue
//  Description : Self-checking bench for inst_queue (DEPTH = 4) using a
//                queue-based reference model, directed steps and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        push_valid;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        push_miss;
  logic        push_illegal;
  logic        push_invalid;
  logic        push_ready;
  logic        pop_ready;
  logic        pop_valid;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic        pop_miss;
  logic        pop_illegal;
  logic        pop_invalid;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  int illegal_seen = 0;

  // Reference model: entries packed as {pc, instr, miss, illegal, invalid}.
  logic [66:0] mq[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .push_miss(push_miss), .push_illegal(push_illegal), .push_invalid(push_invalid),
    .push_ready(push_ready), .pop_ready(pop_ready), .pop_valid(pop_valid),
    .pop_pc(pop_pc), .pop_instr(pop_instr), .pop_miss(pop_miss),
    .pop_illegal(pop_illegal), .pop_invalid(pop_invalid), .count(count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs against the model's view of the queue.
  task automatic check_outputs(input string tag);
    logic [66:0] h;
    h = (mq.size() != 0) ? mq[0] : 67'd0;
    chk({tag, ".count"},      {29'd0, count},                     mq.size());
    chk({tag, ".push_ready"}, {31'd0, push_ready},                {31'd0, mq.size() != DEPTH});
    chk({tag, ".pop_valid"},  {31'd0, pop_valid},                 {31'd0, mq.size() != 0});
    chk({tag, ".pop_pc"},     pop_pc,                             h[66:35]);
    chk({tag, ".pop_instr"},  pop_instr,                          h[34:3]);
    chk({tag, ".pop_flags"},  {29'd0, pop_miss, pop_illegal, pop_invalid}, {29'd0, h[2:0]});
  endtask

  // One clock cycle: drive, check the head before the edge, advance the model.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [2:0] fl, input logic pr, input logic fs, input string tag);
    bit do_push, do_pop;
    push_valid = pv; push_pc = pc; push_instr = ins;
    {push_miss, push_illegal, push_invalid} = fl;
    pop_ready = pr; flush = fs;
    check_outputs(tag);
    if (pop_valid && pr && pop_illegal) illegal_seen++;
    do_push = pv && (mq.size() != DEPTH);
    do_pop  = pr && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (fs) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, ins, fl});
    end
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_pc = '0; push_instr = '0; push_miss = 1'b0; push_illegal = 1'b0; push_invalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_outputs("reset_state");

    // Asynchronous reset while holding two entries.
    step(1'b1, 32'h100, 32'hAAAA0001, 3'b000, 1'b0, 1'b0, "rst_fill0");
    step(1'b1, 32'h104, 32'hAAAA0002, 3'b001, 1'b0, 1'b0, "rst_fill1");
    chk("rst_pre_count", {29'd0, count}, 32'd2);
    #2 reset = 1'b1;
    #1;
    mq.delete();
    chk("rst_async_count", {29'd0, count}, 32'd0);
    chk("rst_async_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("rst_async_pop_instr", pop_instr, 32'd0);
    chk("rst_async_push_ready", {31'd0, push_ready}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    check_outputs("rst_after");

    // Fill with decode stalled, then a refused 5th push, then drain.
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'hbfc00000 + 32'(4 * k), 32'h11 * 32'(k + 1), 3'b000, 1'b0, 1'b0, "fill");
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_push_ready", {31'd0, push_ready}, 32'd0);
    step(1'b1, 32'hbfc00010, 32'h55, 3'b000, 1'b0, 1'b0, "refused_push");
    for (int k = 0; k < 4; k++) begin
      chk("drain_instr", pop_instr, 32'h11 * 32'(k + 1));
      step(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, "drain");
    end
    chk("drain_empty", {31'd0, pop_valid}, 32'd0);
    step(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, "pop_on_empty");

    // Steady state push+pop with two entries resident.
    step(1'b1, 32'h2000, 32'hC0DE0000, 3'b000, 1'b0, 1'b0, "ss_pre0");
    step(1'b1, 32'h2004, 32'hC0DE0001, 3'b000, 1'b0, 1'b0, "ss_pre1");
    for (int k = 0; k < 10; k++) begin
      chk("ss_delay2", pop_instr, 32'hC0DE0000 + 32'(k));
      step(1'b1, 32'h2008 + 32'(4 * k), 32'hC0DE0002 + 32'(k), 3'b000, 1'b1, 1'b0, "ss");
      chk("ss_count", {29'd0, count}, 32'd2);
    end

    // Full with a simultaneous pop: push refused, slot opens next cycle.
    step(1'b1, 32'h3000, 32'hF0000000, 3'b000, 1'b0, 1'b0, "top_up0");
    step(1'b1, 32'h3004, 32'hF0000001, 3'b000, 1'b0, 1'b0, "top_up1");
    step(1'b1, 32'h3008, 32'hF0000002, 3'b010, 1'b1, 1'b0, "full_pop");
    chk("full_pop_count", {29'd0, count}, 32'd3);
    chk("full_pop_push_ready", {31'd0, push_ready}, 32'd1);

    // Flush with concurrent push and pop.
    step(1'b1, 32'h4000, 32'hDEADBEEF, 3'b100, 1'b1, 1'b1, "flush");
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("flush_push_ready", {31'd0, push_ready}, 32'd1);
    step(1'b1, 32'h4004, 32'h12345678, 3'b000, 1'b0, 1'b0, "post_flush_push");
    chk("post_flush_head", pop_instr, 32'h12345678);
    step(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, "post_flush_pop");

    // Wrap twice; only the 6th entry carries an illegal-address flag.
    illegal_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (k >= 1 && pop_illegal) chk("wrap_illegal_pc", pop_pc, 32'h80000014);
      if (k < 9)
        step(1'b1, 32'h80000000 + 32'(4 * k), 32'h900 + 32'(k),
             (k == 5) ? 3'b010 : 3'b000, 1'b1, 1'b0, "wrap");
      else
        step(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, "wrap_last");
    end
    chk("wrap_illegal_once", illegal_seen, 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), "rand");
    check_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage. It decouples instruction-return timing from decode stalls: it buffers up to DEPTH fetched instructions together with their PC and fetch-exception flags, and presents them to decode in order. Fetch advances while `push_ready` is high. Decode consumes an entry by asserting `pop_ready`. An exception flush empties the queue in one cycle.

## Interface
- `DEPTH`, default 4: number of entries; a power of two, at least 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: exception/redirect flush (driven from `expFlush`); synchronous.
- `push_valid` in 1: fetch is offering an instruction this cycle.
- `push_pc` in 32: PC of the offered instruction.
- `push_instr` in 32: instruction word.
- `push_miss`, `push_illegal`, `push_invalid` in 1 each: fetch-exception flags (TLB miss, illegal address, invalid entry).
- `push_ready` out 1: queue can accept a push this cycle.
- `pop_ready` in 1: decode accepts the head entry this cycle (low while decode stalls).
- `pop_valid` out 1: head entry is valid.
- `pop_pc` out 32: PC field of the head entry.
- `pop_instr` out 32: instruction field of the head entry.
- `pop_miss`, `pop_illegal`, `pop_invalid` out 1 each: flag fields of the head entry.
- `count` out log2(DEPTH)+1: number of occupied entries.

## Operation
- Storage: DEPTH entries, each 67 bits (pc 32, instr 32, miss, illegal, invalid).
- Pointers: write pointer and read pointer, log2(DEPTH) bits each, wrapping modulo DEPTH. `count` is held in a separate register, 0..DEPTH.
- `push_ready` = (`count` != DEPTH). It is purely registered-state based and does not depend on `pop_ready`. When full, a push is refused even if a pop occurs in the same cycle.
- Push fires when `push_valid` & `push_ready`:
  - writes the entry at the write pointer;
  - increments the write pointer.
- Pop fires when `pop_valid` & `pop_ready`: increments the read pointer.
- Count update:
  - push only: +1;
  - pop only: −1;
  - both: unchanged;
  - neither: unchanged.
- `pop_valid` = (`count` != 0).
- Head outputs are a combinational read of the entry at the read pointer, gated:
  - when `pop_valid` = 0, `pop_pc`, `pop_instr` and all pop flags drive 0 (decode sees a NOP with no exception);
  - when `pop_valid` = 1, they drive the head entry.
- Flush has the highest priority. At the clock edge where `flush` = 1:
  - both pointers and `count` become 0;
  - any push or pop in that cycle is discarded;
  - storage contents are not cleared.
- No data is reordered or duplicated. Entries leave in push order, including entries carrying exception flags. Flags travel unmodified.

## Timing
- Reset (asynchronous, immediate): pointers = 0, `count` = 0.
  - Outputs during and after reset: `pop_valid` = 0; `pop_pc`, `pop_instr`, `pop_miss`, `pop_illegal`, `pop_invalid` = 0; `push_ready` = 1; `count` = 0.
- Push-to-pop latency: 1 cycle. An entry pushed at edge N is visible at the pop side after edge N; there is no same-cycle bypass when empty.
- Throughput: 1 push and 1 pop per cycle sustained whenever 0 < `count` < DEPTH.
- Full (`count` = DEPTH): `push_ready` = 0. A simultaneous pop frees a slot; `push_ready` rises in the following cycle.
- Empty: `pop_ready` is ignored and the pointers do not move.
- Wrap-around: pointer DEPTH−1 increments to 0. Ordering holds across the wrap.
- Reset mid-operation: all contents are discarded; the state is identical to power-on.
- Flush deasserted: `push_ready` = 1 in the cycle after the flush edge, so fetch may push immediately.

## Test plan
- Reset: assert `reset` while the queue holds 2 entries. Required: `count` = 0, `pop_valid` = 0 and `pop_instr` = 0 immediately (asynchronously); `push_ready` = 1.
- Fill and drain (DEPTH = 4, `pop_ready` = 0): push instr 0x11, 0x22, 0x33, 0x44 with PC 0xbfc00000 + 4k.
  - After the 4th edge: `count` = 4, `push_ready` = 0; a 5th push of 0x55 is refused.
  - Then raise `pop_ready`: 0x11, 0x22, 0x33, 0x44 appear on consecutive cycles, then `pop_valid` = 0.
- Simultaneous push/pop: with `count` = 2, push and pop for 10 cycles. Required: `count` stays 2; the output sequence equals the input sequence, delayed by 2 entries.
- Full with pop: with `count` = 4, push_valid = 1 and pop_ready = 1 for one cycle. Required: the push is refused, `count` = 3, and `push_ready` = 1 in the next cycle.
- Flush: with `count` = 3, assert `flush` together with push_valid and pop_ready. Required: next cycle `count` = 0, `pop_valid` = 0, the pushed entry never appears, and `push_ready` = 1.
- Wrap and flags: run 9 push/pop pairs so the pointers wrap twice. The 6th entry carries `push_illegal` = 1 with PC 0x80000014. Required: exactly that popped entry shows `pop_illegal` = 1 and `pop_pc` = 0x80000014; all other entries show flags 0.
